uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_tx instance between N_REQ byte requesters (buttons, heartbeat, status sources).
//   Round-robin arbitration accepts one byte per frame, drives the uart_tx data_rdy/data pair,
//   and sequences the launch -> busy -> idle handshake. Also flags frames that fail to start.
//   Sits between application byte sources and uart_tx, in the same sysclk domain.
// PARAMETERS
//   N_REQ           4     number of requesters, 2..8
//   DATA_BITS       8     byte width, must match uart_tx DATA_BITS
//   LAUNCH_TIMEOUT  4096  sysclk cycles to wait for tx_busy_in to rise after data_rdy_out is raised
// PORTS
//   sysclk_in       in   1                clock, rising edge
//   nrst_in         in   1                asynchronous active-low reset
//   req_valid_in    in   N_REQ            requester i has a byte; held until accepted
//   req_data_in     in   N_REQ*DATA_BITS  byte of requester i at bits [i*DATA_BITS +: DATA_BITS]
//   req_ready_out   out  N_REQ            one-cycle accept pulse, one-hot
//   tx_busy_in      in   1                uart_tx tx_busy_out
//   data_rdy_out    out  1                to uart_tx data_rdy_in
//   tx_data_out     out  DATA_BITS        to uart_tx tx_data_in, stable while not IDLE
//   grant_id_out    out  $clog2(N_REQ)    index of last accepted requester
//   frame_done_out  out  1                one-cycle pulse when a frame completes
//   timeout_out     out  1                one-cycle pulse when a launch times out
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE; all outputs 0; RR pointer 0; timeout counter 0.
//   FSM states IDLE, LAUNCH, WAIT_DONE:
//   - IDLE: if |req_valid_in and tx_busy_in==0, grant g = first valid index at or after ptr, modulo N_REQ.
//     Same cycle: req_ready_out[g]=1 (combinational from registered state). Next edge: latch tx_data_out,
//     grant_id_out<=g, ptr<=(g+1)%N_REQ, data_rdy_out<=1, ->LAUNCH. No valid, or busy=1: stay in IDLE.
//   - LAUNCH: hold data_rdy_out=1 and count cycles. tx_busy_in==1: data_rdy_out<=0, ->WAIT_DONE.
//     Count reaches LAUNCH_TIMEOUT-1 with busy still 0: data_rdy_out<=0, timeout_out pulse,
//     ->IDLE. The byte is dropped, not retried.
//   - WAIT_DONE: tx_busy_in==0 -> frame_done_out pulse, ->IDLE.
//     Earliest next accept is the cycle after the IDLE return, so gaps between frames are >=2 cycles.
//   Throughput and latency: accept -> data_rdy_out high in 1 cycle. One byte in flight; no internal FIFO.
//   Fairness: a requester that stays valid waits at most N_REQ-1 frames.
//   Simultaneous valids at reset release: index 0 wins first.
//   req_ready_out is 0 in LAUNCH and WAIT_DONE whatever the valids are.
//   A valid dropped before accept is legal and is ignored; the pointer does not move.
//   Reset mid-frame: everything returns to reset values at once, and data_rdy_out falls asynchronously.
//   Any uart_tx frame already started finishes on its own.
//   Timeout counter width is $clog2(LAUNCH_TIMEOUT+1); it clears on every entry to LAUNCH.
//   N_REQ==1 degenerates to a pass-through sequencer with grant_id_out fixed at 0.
// STRUCTURE
//   Package uart_pkg: DATA_BITS default, enum arb_state_t {IDLE, LAUNCH, WAIT_DONE}, LAUNCH_TIMEOUT default.
//   Sub-module rr_arbiter #(N): inputs req, ptr; outputs onehot grant and encoded index.
//   rr_arbiter is purely combinational and reusable for other shared resources.
//   The top level holds the FSM, data latch, pointer and timeout counter.
// TESTING  (bench instantiates baud_generator, 100 MHz / 115200 / x8, plus uart_tx and a serial decoder)
//   1. Single request: req0 valid with 8'h61 -> one ready pulse on bit0, serial byte 0x61 decoded,
//      frame_done_out pulses once.
//   2. All four valid with 61/62/63/64, held -> accept order 0,1,2,3 and bytes 61,62,63,64 on the line.
//   3. Fairness: req1 held valid continuously, req3 raised mid-frame -> next grants 3, then 1, then 1.
//      req1 is never granted twice while req3 is waiting.
//   4. Timeout: tx_busy_in tied 0, req2=8'h2E -> data_rdy_out high for exactly LAUNCH_TIMEOUT cycles,
//      then timeout_out pulses and the FSM returns to IDLE.
//   5. Reset mid-frame: nrst_in low during WAIT_DONE -> all outputs 0 immediately.
//      After release with req0 valid, the first grant is 0.
//   6. Busy at entry: tx_busy_in=1 with req0 valid in IDLE -> no ready pulse until busy falls,
//      then ready within 1 cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   UART_DATA_BITS       default byte width (must match uart_tx)
//   UART_LAUNCH_TIMEOUT  default cycles to wait for uart_tx to report busy
//   arb_state_t          arbiter FSM states
//   idx_width()          width of an index into n requesters (never below 1)
package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_LAUNCH_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit index so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared resource.
//   req          in   N    request vector
//   ptr          in   IW   index with highest priority this cycle
//   grant        out  N    one-hot grant (all zero when no request)
//   grant_index  out  IW   encoded index of the granted request
//   grant_vld    out  1    at least one request present
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_index,
    output logic          grant_vld
);

    localparam int SW = IW + 1;

    logic [N-1:0]  rot_s;
    logic [IW-1:0] off_s;
    logic [SW-1:0] sum_s;
    logic          found_s;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation modulo N.
    always_comb begin
        rot_s   = N'({req, req} >> ptr);
        found_s = 1'b0;
        off_s   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                off_s   = IW'(k);
            end else begin
                found_s = found_s;
            end
        end
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= SW'(N)) begin
            grant_index = IW'(sum_s - SW'(N));
        end else begin
            grant_index = IW'(sum_s);
        end
        grant     = found_s ? (N'(1'b1) << grant_index) : '0;
        grant_vld = found_s;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte requesters. Round-robin picks one byte per
// frame, drives the uart_tx data_rdy/data pair and sequences launch -> busy -> idle.
// A launch that never sees tx_busy_in rise within LAUNCH_TIMEOUT cycles is dropped
// and flagged on timeout_out.
//   sysclk_in       in   1                 clock, rising edge
//   nrst_in         in   1                 asynchronous active-low reset
//   req_valid_in    in   N_REQ             requester has a byte, held until accepted
//   req_data_in     in   N_REQ*DATA_BITS   byte of requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ready_out   out  N_REQ             one-hot accept pulse
//   tx_busy_in      in   1                 uart_tx busy
//   data_rdy_out    out  1                 to uart_tx data_rdy_in
//   tx_data_out     out  DATA_BITS         to uart_tx tx_data_in
//   grant_id_out    out  idx width         last accepted requester
//   frame_done_out  out  1                 pulse when a frame completes
//   timeout_out     out  1                 pulse when a launch times out
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_BITS      = UART_DATA_BITS,
    parameter int LAUNCH_TIMEOUT = UART_LAUNCH_TIMEOUT
) (
    input  logic                          sysclk_in,
    input  logic                          nrst_in,
    input  logic [N_REQ-1:0]              req_valid_in,
    input  logic [N_REQ*DATA_BITS-1:0]    req_data_in,
    output logic [N_REQ-1:0]              req_ready_out,
    input  logic                          tx_busy_in,
    output logic                          data_rdy_out,
    output logic [DATA_BITS-1:0]          tx_data_out,
    output logic [idx_width(N_REQ)-1:0]   grant_id_out,
    output logic                          frame_done_out,
    output logic                          timeout_out
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);

    arb_state_t            state_r, state_s;
    logic [IW-1:0]         ptr_r, ptr_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic                  data_rdy_r, data_rdy_s;
    logic [DATA_BITS-1:0]  tx_data_r, tx_data_s;
    logic [IW-1:0]         grant_id_r, grant_id_s;
    logic                  frame_done_r, frame_done_s;
    logic                  timeout_r, timeout_s;
    logic [N_REQ-1:0]      ready_s;

    logic [N_REQ-1:0]      arb_grant_s;
    logic [IW-1:0]         arb_idx_s;
    logic                  arb_vld_s;
    logic [DATA_BITS-1:0]  sel_data_s;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req         (req_valid_in),
        .ptr         (ptr_r),
        .grant       (arb_grant_s),
        .grant_index (arb_idx_s),
        .grant_vld   (arb_vld_s)
    );

    // AND-OR mux of the granted requester's byte.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data_s = sel_data_s |
                         (req_data_in[i*DATA_BITS +: DATA_BITS] & {DATA_BITS{arb_grant_s[i]}});
        end
    end

    // Next-state and next-output logic of the arbiter FSM.
    always_comb begin
        state_s      = state_r;
        ptr_s        = ptr_r;
        cnt_s        = cnt_r;
        data_rdy_s   = data_rdy_r;
        tx_data_s    = tx_data_r;
        grant_id_s   = grant_id_r;
        frame_done_s = 1'b0;
        timeout_s    = 1'b0;
        ready_s      = '0;
        case (state_r)
            IDLE: begin
                if (arb_vld_s && !tx_busy_in) begin
                    ready_s    = arb_grant_s;
                    tx_data_s  = sel_data_s;
                    grant_id_s = arb_idx_s;
                    ptr_s      = (arb_idx_s == IW'(N_REQ - 1)) ? '0 : arb_idx_s + IW'(1'b1);
                    data_rdy_s = 1'b1;
                    cnt_s      = '0;
                    state_s    = LAUNCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH: begin
                if (tx_busy_in) begin
                    data_rdy_s = 1'b0;
                    state_s    = WAIT_DONE;
                end else if (cnt_r == CW'(LAUNCH_TIMEOUT - 1)) begin
                    // Byte is dropped, not retried.
                    data_rdy_s = 1'b0;
                    timeout_s  = 1'b1;
                    state_s    = IDLE;
                end else begin
                    cnt_s = cnt_r + CW'(1'b1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_in) begin
                    frame_done_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                data_rdy_s = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pointer, counter and registered outputs.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            ptr_r        <= '0;
            cnt_r        <= '0;
            data_rdy_r   <= 1'b0;
            tx_data_r    <= '0;
            grant_id_r   <= '0;
            frame_done_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            ptr_r        <= ptr_s;
            cnt_r        <= cnt_s;
            data_rdy_r   <= data_rdy_s;
            tx_data_r    <= tx_data_s;
            grant_id_r   <= grant_id_s;
            frame_done_r <= frame_done_s;
            timeout_r    <= timeout_s;
        end
    end

    // The accept pulse is combinational, so mask it while reset is held to keep every output low.
    assign req_ready_out  = ready_s & {N_REQ{nrst_in}};
    assign data_rdy_out   = data_rdy_r;
    assign tx_data_out    = tx_data_r;
    assign grant_id_out   = grant_id_r;
    assign frame_done_out = frame_done_r;
    assign timeout_out    = timeout_r;

endmodule
